// File: rtl/mem_latency_interface.sv
// mem_latency_interface
//   Byte-addressed, little-endian data memory with a valid/ready request port,
//   a fixed configurable access latency and a coded, registered response.
//   Supports byte/half/word loads (sign or zero extended) and lane-masked
//   stores. Misaligned, illegal-size and out-of-range requests answer ERROR
//   and leave memory untouched.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no request in flight, ready to accept
//   BUSY  | request captured, latency counter running down to 0
//   RESP  | one-cycle response strobe; may accept the next request
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   i_req_valid       request present
//   o_req_ready       request accepted this cycle if valid (0 only in BUSY)
//   i_req_addr        byte address
//   i_req_wr_en       1 = store, 0 = load
//   i_req_wr_data     store data, right-aligned
//   i_req_count       0 = byte, 1 = half, 2 = word, 3 = illegal
//   i_req_signed      sign-extend load data
//   o_res_valid       high exactly in RESP
//   o_res_code        0 IDLE, 1 BUSY, 2 DONE, 3 ERROR
//   o_res_rd_data     load result, right-aligned and extended

module mem_latency_interface #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_wr_en,
  input  logic [WORD_W-1:0] i_req_wr_data,
  input  logic [1:0]        i_req_count,
  input  logic              i_req_signed,
  output logic              o_res_valid,
  output logic [1:0]        o_res_code,
  output logic [WORD_W-1:0] o_res_rd_data
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] CODE_IDLE  = 2'd0;
  localparam logic [1:0] CODE_BUSY  = 2'd1;
  localparam logic [1:0] CODE_DONE  = 2'd2;
  localparam logic [1:0] CODE_ERROR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        count_q, count_d;
  logic              signed_q, signed_d;
  logic [1:0]        res_code_q, res_code_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

  // Contents survive reset; the initializer only gives simulation a known
  // starting image.
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic              accept;
  logic              finish;
  logic              err;
  logic              out_of_range;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] load_val;
  logic [3:0]        lane_en;
  logic [WORD_W-1:0] wr_lanes;
  logic              store_commit;

  assign o_req_ready = (state_q != S_BUSY);
  assign o_res_valid = (state_q == S_RESP);
  assign o_res_code  = res_code_q;
  assign o_res_rd_data = rd_data_q;

  assign accept = i_req_valid && o_req_ready;
  assign finish = (state_q == S_BUSY) && (cnt_q == 4'd0);

  // Request checks operate on the captured fields, never on the live inputs.
  assign word_idx     = addr_q[ADDR_W-1:2];
  assign out_of_range = ({2'b00, word_idx} >= ADDR_W'(DEPTH_WORDS));
  assign mem_idx      = word_idx[IDX_W-1:0];

  always_comb begin
    err = out_of_range;
    case (count_q)
      2'd1:    if (addr_q[0])           err = 1'b1;
      2'd2:    if (addr_q[1:0] != 2'b0) err = 1'b1;
      2'd3:                             err = 1'b1;
      default: ;
    endcase
  end

  // Load path: bring the addressed lane(s) down to bit 0, then extend.
  assign rd_word = mem_q[mem_idx];
  assign shifted = rd_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = shifted;
    case (count_q)
      2'd0: load_val = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'b0, shifted[7:0]};
      2'd1: load_val = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                : {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Store path: replicate the right-aligned data into every lane and let the
  // lane enables pick which ones land.
  always_comb begin
    lane_en  = 4'b1111;
    wr_lanes = wr_data_q;
    case (count_q)
      2'd0: begin
        lane_en  = 4'b0001 << addr_q[1:0];
        wr_lanes = {4{wr_data_q[7:0]}};
      end
      2'd1: begin
        lane_en  = 4'b0011 << {addr_q[1], 1'b0};
        wr_lanes = {2{wr_data_q[15:0]}};
      end
      default: begin
        lane_en  = 4'b1111;
        wr_lanes = wr_data_q;
      end
    endcase
  end

  // Reset on the commit edge discards the pending store.
  assign store_commit = finish && wr_en_q && !err && !reset;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wr_en_d    = wr_en_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    signed_d   = signed_q;
    rd_data_d  = rd_data_q;
    res_code_d = res_code_q;

    if (accept) begin
      addr_d    = i_req_addr;
      wr_en_d   = i_req_wr_en;
      wr_data_d = i_req_wr_data;
      count_d   = i_req_count;
      signed_d  = i_req_signed;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = LAT_LOAD;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = S_RESP;
          rd_data_d = (wr_en_q || err) ? '0 : load_val;
        end
      end
      S_RESP: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = LAT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The response code is registered, so it follows the state being entered.
    case (state_d)
      S_BUSY:  res_code_d = CODE_BUSY;
      S_RESP:  res_code_d = err ? CODE_ERROR : CODE_DONE;
      default: res_code_d = CODE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      count_q    <= 2'd0;
      signed_q   <= 1'b0;
      rd_data_q  <= '0;
      res_code_q <= CODE_IDLE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      count_q    <= count_d;
      signed_q   <= signed_d;
      rd_data_q  <= rd_data_d;
      res_code_q <= res_code_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem_q[mem_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_latency_interface.sv
module tb_mem_latency_interface;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_BUSY = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;
  localparam logic [1:0] C_ERR  = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_wr_en;
  logic [31:0] i_req_wr_data;
  logic [1:0]  i_req_count;
  logic        i_req_signed;
  logic        o_res_valid;
  logic [1:0]  o_res_code;
  logic [31:0] o_res_rd_data;

  always #5 clk = ~clk;

  mem_latency_interface #(
    .WORD_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_wr_en(i_req_wr_en),
    .i_req_wr_data(i_req_wr_data), .i_req_count(i_req_count),
    .i_req_signed(i_req_signed),
    .o_res_valid(o_res_valid), .o_res_code(o_res_code),
    .o_res_rd_data(o_res_rd_data)
  );

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [1:0]  cnt;
    logic        sgn;
    logic [1:0]  code;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic [31:0] addr,
                              input logic wr, input logic [31:0] data,
                              input logic [1:0] cnt, input logic sgn,
                              input logic [1:0] code, input logic [31:0] rdata);
    vec_t v;
    v.name = name; v.addr = addr; v.wr = wr; v.data = data;
    v.cnt = cnt; v.sgn = sgn; v.code = code; v.rdata = rdata;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic wr,
                       input logic [31:0] data, input logic [1:0] cnt,
                       input logic sgn);
    i_req_addr    = addr;
    i_req_wr_en   = wr;
    i_req_wr_data = data;
    i_req_count   = cnt;
    i_req_signed  = sgn;
    i_req_valid   = 1'b1;
  endtask

  // Starts at a negedge; returns at the negedge where o_res_valid is seen
  // (or the budget runs out), with valid already dropped.
  task automatic issue(input string name, input logic [31:0] addr,
                       input logic wr, input logic [31:0] data,
                       input logic [1:0] cnt, input logic sgn,
                       output logic [1:0] code, output logic [31:0] rd,
                       output int lat);
    int w;
    drive(addr, wr, data, cnt, sgn);
    w = 0;
    while (!o_req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!o_req_ready) begin
      n_total++;
      n_bad++;
      $display("FAIL %s_ready_timeout: got ready=0 expected ready=1", name);
    end
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    lat = 0;
    while (!o_res_valid && lat < 20) begin
      check({name, "_busy_ready"}, {31'b0, o_req_ready}, 32'd0);
      check({name, "_busy_code"}, {30'b0, o_res_code}, {30'b0, C_BUSY});
      @(negedge clk);
      lat++;
    end
    code = o_res_code;
    rd   = o_res_rd_data;
  endtask

  logic [1:0]  got_code;
  logic [31:0] got_rd;
  int          got_lat;
  bit          seen;

  initial begin
    add("st_w_20",     32'h20, 1, 32'h1111_1111, 2, 0, C_DONE, 32'h0);
    add("st_w_28",     32'h28, 1, 32'h2222_2222, 2, 0, C_DONE, 32'h0);
    add("st_w_10",     32'h10, 1, 32'hDEAD_BEEF, 2, 0, C_DONE, 32'h0);
    add("ld_w_10",     32'h10, 0, 32'h0,         2, 0, C_DONE, 32'hDEAD_BEEF);
    add("st_b_11",     32'h11, 1, 32'hFFFF_FF80, 0, 0, C_DONE, 32'h0);
    add("ld_w_10b",    32'h10, 0, 32'h0,         2, 1, C_DONE, 32'hDEAD_80EF);
    add("ld_bs_11",    32'h11, 0, 32'h0,         0, 1, C_DONE, 32'hFFFF_FF80);
    add("ld_bu_11",    32'h11, 0, 32'h0,         0, 0, C_DONE, 32'h0000_0080);
    add("ld_hs_12",    32'h12, 0, 32'h0,         1, 1, C_DONE, 32'hFFFF_DEAD);
    add("ld_hu_12",    32'h12, 0, 32'h0,         1, 0, C_DONE, 32'h0000_DEAD);
    add("ld_bs_10",    32'h10, 0, 32'h0,         0, 1, C_DONE, 32'hFFFF_FFEF);
    add("st_h_12",     32'h12, 1, 32'hABCD_1234, 1, 0, C_DONE, 32'h0);
    add("ld_w_10c",    32'h10, 0, 32'h0,         2, 0, C_DONE, 32'h1234_80EF);
    add("ld_hs_10",    32'h10, 0, 32'h0,         1, 1, C_DONE, 32'hFFFF_80EF);
    add("ld_bu_13",    32'h13, 0, 32'h0,         0, 1, C_DONE, 32'h0000_0012);
    add("err_ld_h_13", 32'h13, 0, 32'h0,         1, 1, C_ERR,  32'h0);
    add("err_st_w_12", 32'h12, 1, 32'hFFFF_FFFF, 2, 0, C_ERR,  32'h0);
    add("err_cnt3",    32'h10, 0, 32'h0,         3, 0, C_ERR,  32'h0);
    add("err_range_l", DEPTH*4, 0, 32'h0,        2, 0, C_ERR,  32'h0);
    add("err_range_s", DEPTH*4, 1, 32'h7777_7777, 0, 0, C_ERR, 32'h0);
    add("ld_w_10_kept",32'h10, 0, 32'h0,         2, 0, C_DONE, 32'h1234_80EF);
    add("st_w_last",   DEPTH*4-4, 1, 32'hCAFE_F00D, 2, 0, C_DONE, 32'h0);
    add("ld_w_last",   DEPTH*4-4, 0, 32'h0,      2, 0, C_DONE, 32'hCAFE_F00D);

    reset = 1'b1;
    i_req_valid = 1'b0; i_req_addr = '0; i_req_wr_en = 1'b0;
    i_req_wr_data = '0; i_req_count = 2'd0; i_req_signed = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, o_req_ready}, 32'd1);
    check("rst_valid", {31'b0, o_res_valid}, 32'd0);
    check("rst_code",  {30'b0, o_res_code}, {30'b0, C_IDLE});
    check("rst_rdata", o_res_rd_data, 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_code",  {30'b0, o_res_code}, {30'b0, C_IDLE});
      check("idle_valid", {31'b0, o_res_valid}, 32'd0);
    end

    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].addr, vecs[i].wr, vecs[i].data,
            vecs[i].cnt, vecs[i].sgn, got_code, got_rd, got_lat);
      check({vecs[i].name, "_lat"},   got_lat, LAT);
      check({vecs[i].name, "_code"},  {30'b0, got_code}, {30'b0, vecs[i].code});
      check({vecs[i].name, "_rdata"}, got_rd, vecs[i].rdata);
      @(negedge clk);
      check({vecs[i].name, "_strobe_end"}, {31'b0, o_res_valid}, 32'd0);
      check({vecs[i].name, "_back_idle"}, {30'b0, o_res_code}, {30'b0, C_IDLE});
    end

    // Back-to-back: store, a stray request during BUSY, then a load of the
    // same address accepted in the store's RESP cycle.
    drive(32'h24, 1, 32'h55AA_55AA, 2, 0);
    @(posedge clk);
    @(negedge clk);
    drive(32'h28, 1, 32'h9999_9999, 2, 0);
    for (int k = 0; k < LAT; k++) begin
      check("b2b_busy_ready", {31'b0, o_req_ready}, 32'd0);
      check("b2b_busy_valid", {31'b0, o_res_valid}, 32'd0);
      @(negedge clk);
    end
    check("b2b_st_valid", {31'b0, o_res_valid}, 32'd1);
    check("b2b_st_code",  {30'b0, o_res_code}, {30'b0, C_DONE});
    check("b2b_st_rdata", o_res_rd_data, 32'h0);
    check("b2b_resp_ready", {31'b0, o_req_ready}, 32'd1);
    drive(32'h24, 0, 32'h0, 2, 0);
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    check("b2b_no_gap_code", {30'b0, o_res_code}, {30'b0, C_BUSY});
    for (int k = 0; k < LAT; k++) begin
      check("b2b_ld_busy_ready", {31'b0, o_req_ready}, 32'd0);
      @(negedge clk);
    end
    check("b2b_ld_valid", {31'b0, o_res_valid}, 32'd1);
    check("b2b_ld_code",  {30'b0, o_res_code}, {30'b0, C_DONE});
    check("b2b_ld_rdata", o_res_rd_data, 32'h55AA_55AA);
    @(negedge clk);
    check("b2b_end_code", {30'b0, o_res_code}, {30'b0, C_IDLE});
    issue("stray_ld_28", 32'h28, 0, 32'h0, 2, 0, got_code, got_rd, got_lat);
    check("stray_ld_28_rdata", got_rd, 32'h2222_2222);
    @(negedge clk);

    // Reset one cycle after accepting a store: no strobe, store dropped.
    drive(32'h20, 1, 32'h1234_5678, 2, 0);
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_code",  {30'b0, o_res_code}, {30'b0, C_IDLE});
    check("rst_mid_ready", {31'b0, o_req_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (o_res_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_mid_no_strobe", {31'b0, seen}, 32'd0);
    issue("rst_mid_ld_20", 32'h20, 0, 32'h0, 2, 0, got_code, got_rd, got_lat);
    check("rst_mid_ld_code",  {30'b0, got_code}, {30'b0, C_DONE});
    check("rst_mid_ld_rdata", got_rd, 32'h1111_1111);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
